// File: rtl/i2c_cmd_queue_if.sv
// ---------------------------------------------------------------------------
// i2c_cmd_queue_if
//   Host-side handshake bundle of the I2C command queue.
//
//   cmd_valid_i  host -> queue  command push request
//   cmd_ready_o  queue -> host  push accepted when high
//   cmd_i        host -> queue  {sta, sto, rd, wr, ack}
//   cmd_dat_i    host -> queue  byte to write
//   rx_valid_o   queue -> host  result queue non-empty
//   rx_ready_i   host -> queue  result pop
//   rx_dat_o     queue -> host  result head {ack, byte}
//
//   slave modport: the queue itself. master modport: the host driving it.
// ---------------------------------------------------------------------------
interface i2c_cmd_queue_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [4:0] cmd_i;
    logic [7:0] cmd_dat_i;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [8:0] rx_dat_o;

    modport slave (
        input  cmd_valid_i, cmd_i, cmd_dat_i, rx_ready_i,
        output cmd_ready_o, rx_valid_o, rx_dat_o
    );

    modport master (
        output cmd_valid_i, cmd_i, cmd_dat_i, rx_ready_i,
        input  cmd_ready_o, rx_valid_o, rx_dat_o
    );
endinterface

// File: rtl/i2c_cmd_queue.sv
// ---------------------------------------------------------------------------
// i2c_cmd_queue
//   Buffers host commands for an I2C byte controller and collects read
//   results. A command FIFO feeds a three-state issuer (IDLE/ISSUE/GAP) that
//   drives registered command strobes; read results return through a
//   result FIFO.
//
//   clk_i, rst_i          clock, synchronous active-high reset
//   ena_i                 core enable; low stops new issues only
//   q_if (slave)          host command push / result pop handshake
//   start_o..ack_o, dat_o byte-controller command strobes and write byte
//   cmd_ack_i             byte-controller command done pulse
//   ack_i, dat_i          received ack bit (1 = NACK) and byte
//   al_i                  arbitration lost: flush and abort
//   clr_i                 clears the sticky al_o / nack_o flags
//   busy_o                a command is in flight
//   cmd_cnt_o             queued command entries, in-flight excluded
//   al_o, nack_o          sticky arbitration-lost and write-NACK flags
// ---------------------------------------------------------------------------
module i2c_cmd_queue #(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ena_i,
    i2c_cmd_queue_if.slave         q_if,
    output logic                   start_o,
    output logic                   stop_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic                   ack_o,
    output logic [7:0]             dat_o,
    input  logic                   cmd_ack_i,
    input  logic                   ack_i,
    input  logic [7:0]             dat_i,
    input  logic                   al_i,
    input  logic                   clr_i,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] cmd_cnt_o,
    output logic                   al_o,
    output logic                   nack_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic sta;
        logic sto;
        logic rd;
        logic wr;
        logic ack;
    } cmd_t;

    typedef struct packed {
        cmd_t       cmd;
        logic [7:0] dat;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;

    // Storage
    entry_t      cmd_mem [DEPTH];
    logic [8:0]  rx_mem  [DEPTH];

    // FIFO bookkeeping
    logic [AW-1:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [AW:0]   cmd_cnt_q, cmd_cnt_d;
    logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [AW:0]   rx_cnt_q, rx_cnt_d;

    // Issuer state and registered outputs
    state_t     state_q;
    cmd_t       strb_q;
    logic [7:0] dat_q;
    logic       al_q;
    logic       nack_q;

    // Combinational control
    entry_t in_entry;
    entry_t head;
    cmd_t   head_strb;
    logic   cmd_empty, cmd_full, rx_full;
    logic   push_acc, push_ok, head_avail, issue;
    logic   cmd_wr_en, cmd_pop;
    logic   rx_push, rx_pop, cmd_done, nack_evt;

    assign in_entry  = {q_if.cmd_i, q_if.cmd_dat_i};
    assign cmd_empty = (cmd_cnt_q == '0);
    assign cmd_full  = (cmd_cnt_q == FULL_CNT);
    assign rx_full   = (rx_cnt_q == FULL_CNT);

    assign q_if.cmd_ready_o = !cmd_full && !al_q;
    assign push_acc = q_if.cmd_valid_i && q_if.cmd_ready_o;
    // Entries with no bus action are dropped; a same-cycle al_i also drops.
    assign push_ok  = push_acc && (in_entry.cmd[4:1] != 4'b0) && !al_i;

    // Done pulse for the in-flight command, unless arbitration was lost.
    assign cmd_done = (state_q == ST_ISSUE) && cmd_ack_i && !al_i;
    assign rx_push  = cmd_done && strb_q.rd;
    assign nack_evt = cmd_done && strb_q.wr && ack_i;
    assign rx_pop   = q_if.rx_ready_i && q_if.rx_valid_o;

    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        // An empty queue forwards the incoming push so it can issue at once.
        head       = cmd_empty ? in_entry : cmd_mem[cmd_rd_q];
        head_avail = !cmd_empty || push_ok;
        head_strb  = head.cmd;
        head_strb.wr = head.cmd.wr & ~head.cmd.rd;  // read wins over write
        // A read only issues when its result has somewhere to go.
        issue      = (state_q == ST_IDLE) && ena_i && head_avail &&
                     (!head.cmd.rd || !rx_full) && !al_i;
        cmd_pop    = issue && !cmd_empty;
        cmd_wr_en  = push_ok && !(issue && cmd_empty);
    end

    always_comb begin
        cmd_wr_d  = cmd_wr_q;
        cmd_rd_d  = cmd_rd_q;
        cmd_cnt_d = cmd_cnt_q;
        rx_wr_d   = rx_wr_q;
        rx_rd_d   = rx_rd_q;
        rx_cnt_d  = rx_cnt_q;

        if (al_i) begin
            cmd_wr_d  = '0;
            cmd_rd_d  = '0;
            cmd_cnt_d = '0;
        end else begin
            if (cmd_wr_en) cmd_wr_d = cmd_wr_q + 1'b1;
            if (cmd_pop)   cmd_rd_d = cmd_rd_q + 1'b1;
            unique case ({cmd_wr_en, cmd_pop})
                2'b10:   cmd_cnt_d = cmd_cnt_q + 1'b1;
                2'b01:   cmd_cnt_d = cmd_cnt_q - 1'b1;
                default: cmd_cnt_d = cmd_cnt_q;
            endcase
        end

        if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
        if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;
        unique case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // NOTE: storage arrays are not reset; validity is carried entirely by
    // the pointers and counts, which are.
    always_ff @(posedge clk_i) begin
        if (cmd_wr_en) cmd_mem[cmd_wr_q] <= in_entry;
        if (rx_push)   rx_mem[rx_wr_q]   <= {ack_i, dat_i};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_wr_q  <= '0;
            cmd_rd_q  <= '0;
            cmd_cnt_q <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            rx_cnt_q  <= '0;
        end else begin
            cmd_wr_q  <= cmd_wr_d;
            cmd_rd_q  <= cmd_rd_d;
            cmd_cnt_q <= cmd_cnt_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
            rx_cnt_q  <= rx_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            strb_q  <= '0;
            dat_q   <= '0;
            al_q    <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            if (al_i) begin
                // Abort whatever is in flight; the FIFO flush happens above.
                state_q <= ST_IDLE;
                strb_q  <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (issue) begin
                            state_q <= ST_ISSUE;
                            strb_q  <= head_strb;
                            dat_q   <= head.dat;
                        end
                    end
                    ST_ISSUE: begin
                        if (cmd_ack_i) begin
                            state_q <= ST_GAP;
                            strb_q  <= '0;
                        end
                    end
                    ST_GAP:  state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end

            // Set events beat a same-cycle clear.
            if (al_i)        al_q <= 1'b1;
            else if (clr_i)  al_q <= 1'b0;
            if (nack_evt)    nack_q <= 1'b1;
            else if (clr_i)  nack_q <= 1'b0;
        end
    end

    assign start_o   = strb_q.sta;
    assign stop_o    = strb_q.sto;
    assign read_o    = strb_q.rd;
    assign write_o   = strb_q.wr;
    assign ack_o     = strb_q.ack;
    assign dat_o     = dat_q;
    assign busy_o    = (state_q == ST_ISSUE);
    assign cmd_cnt_o = cmd_cnt_q;
    assign al_o      = al_q;
    assign nack_o    = nack_q;

    assign q_if.rx_valid_o = (rx_cnt_q != '0);
    // Masked so the head reads zero while the queue is empty.
    assign q_if.rx_dat_o   = q_if.rx_valid_o ? rx_mem[rx_rd_q] : 9'h000;
endmodule

// File: tb/tb_i2c_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_i2c_cmd_queue
//   Self-checking bench for i2c_cmd_queue. Expected issues and results are
//   pushed to scoreboard queues when stimulus is driven and popped when the
//   DUT presents them. Inputs change and outputs are sampled 1 time unit
//   after each rising edge.
// ---------------------------------------------------------------------------
module tb_i2c_cmd_queue;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i, ena_i;
    logic          start_o, stop_o, read_o, write_o, ack_o;
    logic [7:0]    dat_o;
    logic          cmd_ack_i, ack_i;
    logic [7:0]    dat_i;
    logic          al_i, clr_i;
    logic          busy_o;
    logic [CW-1:0] cmd_cnt_o;
    logic          al_o, nack_o;

    i2c_cmd_queue_if q_if ();

    i2c_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ena_i     (ena_i),
        .q_if      (q_if),
        .start_o   (start_o),
        .stop_o    (stop_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .ack_o     (ack_o),
        .dat_o     (dat_o),
        .cmd_ack_i (cmd_ack_i),
        .ack_i     (ack_i),
        .dat_i     (dat_i),
        .al_i      (al_i),
        .clr_i     (clr_i),
        .busy_o    (busy_o),
        .cmd_cnt_o (cmd_cnt_o),
        .al_o      (al_o),
        .nack_o    (nack_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    logic [12:0] exp_iss [$];  // {sta,sto,rd,wr,ack,dat} expected on strobes
    logic [8:0]  exp_rx  [$];  // {ack,byte} expected at rx head
    logic [12:0] e_iss;
    logic [8:0]  e_rx;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [12:0] obs_iss();
        return {start_o, stop_o, read_o, write_o, ack_o, dat_o};
    endfunction

    // One-cycle push; the scoreboard models acceptance, dropping and the
    // read-over-write rule.
    task automatic push_cmd(input logic [4:0] c, input logic [7:0] d);
        q_if.cmd_valid_i = 1'b1;
        q_if.cmd_i       = c;
        q_if.cmd_dat_i   = d;
        #0;
        if (q_if.cmd_ready_o && (c[4:1] != 4'b0) && !al_i)
            exp_iss.push_back({c[4], c[3], c[2], c[1] & ~c[2], c[0], d});
        tick();
        q_if.cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        total++; if (obs_iss() !== 13'h0) begin bad++; $display("FAIL rst_strobes got=%h exp=0", obs_iss()); end
        total++; if ({busy_o, al_o, nack_o, q_if.rx_valid_o} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {busy_o, al_o, nack_o, q_if.rx_valid_o}); end
        total++; if (cmd_cnt_o !== '0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", cmd_cnt_o); end
        total++; if (q_if.cmd_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", q_if.cmd_ready_o); end
        total++; if (q_if.rx_dat_o !== 9'h0) begin bad++; $display("FAIL rst_rxdat got=%h exp=000", q_if.rx_dat_o); end
    endtask

    task automatic test_write_issue();
        ena_i = 1'b1;
        push_cmd(5'b10010, 8'hA0);
        e_iss = exp_iss.pop_front();
        total++; if (obs_iss() !== e_iss) begin bad++; $display("FAIL wr_issue got=%h exp=%h", obs_iss(), e_iss); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", busy_o); end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (obs_iss() !== e_iss) begin bad++; $display("FAIL wr_hold%0d got=%h exp=%h", i, obs_iss(), e_iss); end
        end
        cmd_ack_i = 1'b1; ack_i = 1'b0;
        tick();
        cmd_ack_i = 1'b0;
        total++; if ({start_o, stop_o, read_o, write_o, ack_o} !== 5'b0) begin bad++; $display("FAIL wr_strb_off got=%b exp=00000", {start_o, stop_o, read_o, write_o, ack_o}); end
        total++; if ({busy_o, nack_o} !== 2'b00) begin bad++; $display("FAIL wr_done got=%b exp=00", {busy_o, nack_o}); end
        tick();
    endtask

    task automatic test_read_result();
        push_cmd(5'b00101, 8'h00);
        e_iss = exp_iss.pop_front();
        total++; if (obs_iss() !== e_iss) begin bad++; $display("FAIL rd_issue got=%h exp=%h", obs_iss(), e_iss); end
        cmd_ack_i = 1'b1; ack_i = 1'b1; dat_i = 8'h5C;
        exp_rx.push_back({1'b1, 8'h5C});
        tick();
        cmd_ack_i = 1'b0; ack_i = 1'b0;
        total++; if (q_if.rx_valid_o !== 1'b1) begin bad++; $display("FAIL rd_valid got=%b exp=1", q_if.rx_valid_o); end
        e_rx = exp_rx.pop_front();
        total++; if (q_if.rx_dat_o !== e_rx) begin bad++; $display("FAIL rd_dat got=%h exp=%h", q_if.rx_dat_o, e_rx); end
        total++; if (nack_o !== 1'b0) begin bad++; $display("FAIL rd_no_nack got=%b exp=0", nack_o); end
        q_if.rx_ready_i = 1'b1;
        tick();
        q_if.rx_ready_i = 1'b0;
        total++; if (q_if.rx_valid_o !== 1'b0) begin bad++; $display("FAIL rd_popped got=%b exp=0", q_if.rx_valid_o); end
        // rd and wr together: treated as a read
        push_cmd(5'b00110, 8'h33);
        e_iss = exp_iss.pop_front();
        total++; if (obs_iss() !== e_iss) begin bad++; $display("FAIL rdwr_issue got=%h exp=%h", obs_iss(), e_iss); end
        cmd_ack_i = 1'b1; ack_i = 1'b1; dat_i = 8'h77;
        exp_rx.push_back({1'b1, 8'h77});
        tick();
        cmd_ack_i = 1'b0; ack_i = 1'b0;
        total++; if (nack_o !== 1'b0) begin bad++; $display("FAIL rdwr_no_nack got=%b exp=0", nack_o); end
        e_rx = exp_rx.pop_front();
        total++; if (q_if.rx_dat_o !== e_rx) begin bad++; $display("FAIL rdwr_dat got=%h exp=%h", q_if.rx_dat_o, e_rx); end
        q_if.rx_ready_i = 1'b1;
        tick();
        q_if.rx_ready_i = 1'b0;
    endtask

    task automatic test_nack_clr();
        push_cmd(5'b00010, 8'h11);
        e_iss = exp_iss.pop_front();
        total++; if (obs_iss() !== e_iss) begin bad++; $display("FAIL nk_issue got=%h exp=%h", obs_iss(), e_iss); end
        cmd_ack_i = 1'b1; ack_i = 1'b1;
        tick();
        cmd_ack_i = 1'b0; ack_i = 1'b0;
        total++; if (nack_o !== 1'b1) begin bad++; $display("FAIL nk_set got=%b exp=1", nack_o); end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        total++; if (nack_o !== 1'b0) begin bad++; $display("FAIL nk_clr got=%b exp=0", nack_o); end
        // NACK and clear in the same cycle: NACK wins
        push_cmd(5'b00010, 8'h22);
        e_iss = exp_iss.pop_front();
        cmd_ack_i = 1'b1; ack_i = 1'b1; clr_i = 1'b1;
        tick();
        cmd_ack_i = 1'b0; ack_i = 1'b0; clr_i = 1'b0;
        total++; if (nack_o !== 1'b1) begin bad++; $display("FAIL nk_vs_clr got=%b exp=1", nack_o); end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    task automatic test_drop();
        push_cmd(5'b00001, 8'hFF);
        total++; if ({busy_o, cmd_cnt_o} !== {1'b0, CW'(0)}) begin bad++; $display("FAIL drop got=busy%b cnt%0d exp=busy0 cnt0", busy_o, cmd_cnt_o); end
    endtask

    task automatic test_fill_order();
        ena_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (q_if.cmd_ready_o !== 1'b1) begin bad++; $display("FAIL fill_ready%0d got=%b exp=1", i, q_if.cmd_ready_o); end
            push_cmd(5'b00010, 8'h40 + 8'(i));
        end
        total++; if (q_if.cmd_ready_o !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", q_if.cmd_ready_o); end
        push_cmd(5'b00010, 8'hEE);
        total++; if (cmd_cnt_o !== CW'(DEPTH)) begin bad++; $display("FAIL fill_cnt got=%0d exp=%0d", cmd_cnt_o, DEPTH); end
        ena_i = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            e_iss = exp_iss.pop_front();
            total++; if (obs_iss() !== e_iss) begin bad++; $display("FAIL order%0d got=%h exp=%h", i, obs_iss(), e_iss); end
            if (i == 0) begin
                total++; if (cmd_cnt_o !== CW'(DEPTH - 1)) begin bad++; $display("FAIL order_cnt got=%0d exp=%0d", cmd_cnt_o, DEPTH - 1); end
            end
            tick();
            cmd_ack_i = 1'b1;
            tick();
            cmd_ack_i = 1'b0;
            total++; if ({start_o, stop_o, read_o, write_o, ack_o} !== 5'b0) begin bad++; $display("FAIL gap1_%0d got=%b exp=00000", i, {start_o, stop_o, read_o, write_o, ack_o}); end
            tick();
            total++; if ({start_o, stop_o, read_o, write_o, ack_o} !== 5'b0) begin bad++; $display("FAIL gap2_%0d got=%b exp=00000", i, {start_o, stop_o, read_o, write_o, ack_o}); end
            tick();
        end
    endtask

    task automatic test_al();
        ena_i = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(5'b00010, 8'h60 + 8'(i));
        ena_i = 1'b1;
        tick();
        e_iss = exp_iss.pop_front();
        total++; if (obs_iss() !== e_iss) begin bad++; $display("FAIL al_issue got=%h exp=%h", obs_iss(), e_iss); end
        total++; if (cmd_cnt_o !== CW'(3)) begin bad++; $display("FAIL al_pre_cnt got=%0d exp=3", cmd_cnt_o); end
        al_i = 1'b1;
        tick();
        al_i = 1'b0;
        exp_iss.delete();
        total++; if ({start_o, stop_o, read_o, write_o, ack_o, busy_o} !== 6'b0) begin bad++; $display("FAIL al_strb got=%b exp=000000", {start_o, stop_o, read_o, write_o, ack_o, busy_o}); end
        total++; if (cmd_cnt_o !== '0) begin bad++; $display("FAIL al_cnt got=%0d exp=0", cmd_cnt_o); end
        total++; if ({al_o, q_if.cmd_ready_o} !== 2'b10) begin bad++; $display("FAIL al_flag got=%b exp=10", {al_o, q_if.cmd_ready_o}); end
        push_cmd(5'b00010, 8'h99);
        total++; if (cmd_cnt_o !== '0) begin bad++; $display("FAIL al_blocked got=%0d exp=0", cmd_cnt_o); end
        al_i = 1'b1; clr_i = 1'b1;
        tick();
        al_i = 1'b0;
        total++; if (al_o !== 1'b1) begin bad++; $display("FAIL al_vs_clr got=%b exp=1", al_o); end
        tick();
        clr_i = 1'b0;
        total++; if ({al_o, q_if.cmd_ready_o} !== 2'b01) begin bad++; $display("FAIL al_clr got=%b exp=01", {al_o, q_if.cmd_ready_o}); end
        // al_i beats a same-cycle push
        al_i = 1'b1;
        push_cmd(5'b00010, 8'h98);
        al_i = 1'b0;
        total++; if ({busy_o, cmd_cnt_o} !== {1'b0, CW'(0)}) begin bad++; $display("FAIL al_push got=busy%b cnt%0d exp=busy0 cnt0", busy_o, cmd_cnt_o); end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        // al_i beats a same-cycle cmd_ack_i on a read
        push_cmd(5'b00100, 8'h00);
        e_iss = exp_iss.pop_front();
        al_i = 1'b1; cmd_ack_i = 1'b1; dat_i = 8'h99;
        tick();
        al_i = 1'b0; cmd_ack_i = 1'b0;
        total++; if ({q_if.rx_valid_o, read_o} !== 2'b00) begin bad++; $display("FAIL al_ack got=%b exp=00", {q_if.rx_valid_o, read_o}); end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    task automatic test_rx_full();
        bit seen;
        int guard;
        for (int i = 0; i < DEPTH; i++) begin
            push_cmd(5'b00100, 8'h00);
            e_iss = exp_iss.pop_front();
            total++; if (obs_iss() !== e_iss) begin bad++; $display("FAIL rxf_issue%0d got=%h exp=%h", i, obs_iss(), e_iss); end
            cmd_ack_i = 1'b1; ack_i = i[0]; dat_i = 8'h80 + 8'(i);
            exp_rx.push_back({i[0], 8'h80 + 8'(i)});
            tick();
            cmd_ack_i = 1'b0; ack_i = 1'b0;
            tick();
        end
        push_cmd(5'b00100, 8'h00);
        tick();
        total++; if ({busy_o, cmd_cnt_o} !== {1'b0, CW'(1)}) begin bad++; $display("FAIL rxf_stall got=busy%b cnt%0d exp=busy0 cnt1", busy_o, cmd_cnt_o); end
        e_rx = exp_rx.pop_front();
        total++; if (q_if.rx_dat_o !== e_rx) begin bad++; $display("FAIL rxf_head got=%h exp=%h", q_if.rx_dat_o, e_rx); end
        q_if.rx_ready_i = 1'b1;
        tick();
        q_if.rx_ready_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            if (read_o === 1'b1) seen = 1'b1;
            else tick();
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rxf_resume got=no_issue exp=issue"); end
        e_iss = exp_iss.pop_front();
        total++; if (obs_iss() !== e_iss) begin bad++; $display("FAIL rxf_resume_iss got=%h exp=%h", obs_iss(), e_iss); end
        cmd_ack_i = 1'b1; dat_i = 8'hC5;
        exp_rx.push_back({1'b0, 8'hC5});
        tick();
        cmd_ack_i = 1'b0;
        guard = 0;
        while (q_if.rx_valid_o === 1'b1 && guard < 2 * DEPTH && exp_rx.size() > 0) begin
            e_rx = exp_rx.pop_front();
            total++; if (q_if.rx_dat_o !== e_rx) begin bad++; $display("FAIL rxf_drain%0d got=%h exp=%h", guard, q_if.rx_dat_o, e_rx); end
            q_if.rx_ready_i = 1'b1;
            tick();
            q_if.rx_ready_i = 1'b0;
            guard++;
        end
        total++; if (exp_rx.size() != 0 || q_if.rx_valid_o !== 1'b0) begin bad++; $display("FAIL rxf_left got=%0d_valid%b exp=0_valid0", exp_rx.size(), q_if.rx_valid_o); end
    endtask

    task automatic test_reset_mid();
        push_cmd(5'b00100, 8'h00);
        push_cmd(5'b00010, 8'h01);
        push_cmd(5'b00010, 8'h02);
        total++; if ({busy_o, cmd_cnt_o} !== {1'b1, CW'(2)}) begin bad++; $display("FAIL rm_pre got=busy%b cnt%0d exp=busy1 cnt2", busy_o, cmd_cnt_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_iss.delete();
        total++; if (obs_iss() !== 13'h0) begin bad++; $display("FAIL rm_strobes got=%h exp=0", obs_iss()); end
        total++; if ({busy_o, al_o, nack_o, q_if.rx_valid_o, q_if.cmd_ready_o} !== 5'b00001) begin bad++; $display("FAIL rm_flags got=%b exp=00001", {busy_o, al_o, nack_o, q_if.rx_valid_o, q_if.cmd_ready_o}); end
        total++; if ({cmd_cnt_o, q_if.rx_dat_o} !== {CW'(0), 9'h0}) begin bad++; $display("FAIL rm_cnt got=%0d/%h exp=0/000", cmd_cnt_o, q_if.rx_dat_o); end
        cmd_ack_i = 1'b1; dat_i = 8'h12;
        tick();
        cmd_ack_i = 1'b0;
        total++; if (q_if.rx_valid_o !== 1'b0) begin bad++; $display("FAIL rm_late_ack got=%b exp=0", q_if.rx_valid_o); end
    endtask

    initial begin
        rst_i = 1'b1; ena_i = 1'b0;
        q_if.cmd_valid_i = 1'b0; q_if.cmd_i = '0; q_if.cmd_dat_i = '0;
        q_if.rx_ready_i = 1'b0;
        cmd_ack_i = 1'b0; ack_i = 1'b0; dat_i = '0;
        al_i = 1'b0; clr_i = 1'b0;
        tick();
        test_reset();
        test_write_issue();
        test_read_result();
        test_nack_clr();
        test_drop();
        test_fill_order();
        test_al();
        test_rx_full();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/i2c_cmd_queue.md
I2C_CMD_QUEUE -- requirements
Module: i2c_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving entries per queue; power of two, >= 2.
REQ-002 SHALL have one clock; reset is synchronous and active-high: clk_i  in  1  clock; rst_i  in  1  sync active-high reset.
REQ-003 ena_i  in  1  core enable; low blocks new issues.
REQ-004 cmd_valid_i  in  1  command push request.
REQ-005 cmd_ready_o  out  1  push accepted when high.
REQ-006 cmd_i  in  5  {sta, sto, rd, wr, ack}.
REQ-007 cmd_dat_i  in  8  byte to write.
REQ-008 rx_valid_o  out  1  result queue non-empty.
REQ-009 rx_ready_i  in  1  result pop.
REQ-010 rx_dat_o  out  9  result head {ack, byte}.
REQ-011 start_o, stop_o, read_o, write_o, ack_o  out  1 each  byte-controller command strobes.
REQ-012 dat_o  out  8  byte-controller write data.
REQ-013 cmd_ack_i  in  1  byte-controller command done pulse.
REQ-014 ack_i  in  1  received ack bit (1 = NACK).
REQ-015 dat_i  in  8  received byte.
REQ-016 al_i  in  1  arbitration-lost pulse.
REQ-017 clr_i  in  1  clears al_o and nack_o.
REQ-018 busy_o  out  1  command in flight.
REQ-019 cmd_cnt_o  out  $clog2(DEPTH)+1  queued command entries.
REQ-020 al_o, nack_o  out  1 each  sticky arbitration-lost and write-NACK flags.

Function
REQ-021 SHALL hold a command FIFO of 13-bit entries {cmd_i, cmd_dat_i} and a result FIFO of 9-bit entries, each DEPTH deep.
REQ-022 cmd_ready_o SHALL be combinational: command FIFO not full and al_o low; push occurs on cmd_valid_i & cmd_ready_o.
REQ-023 An accepted entry with sta=sto=rd=wr=0 SHALL be dropped, not stored.
REQ-024 FSM states: IDLE, ISSUE, GAP.
REQ-025 IDLE -> ISSUE when ena_i=1, command FIFO non-empty, and, if head rd=1, result FIFO not full; the head is popped and registered onto the strobes/dat_o.
REQ-026 Strobes SHALL assert the cycle after the IDLE->ISSUE decision; a push in cycle N into an empty queue in IDLE with ena_i=1 SHALL show strobes in cycle N+1.
REQ-027 In ISSUE, strobes and dat_o SHALL stay constant until cmd_ack_i is sampled high in cycle M; strobes SHALL be 0 from M+1; state GAP in M+1, IDLE in M+2; earliest next issue strobes M+3.
REQ-028 When rd and wr are both set, read_o SHALL be 1 and write_o 0.
REQ-029 On cmd_ack_i for a rd command, {ack_i, dat_i} SHALL be pushed to the result FIFO; on cmd_ack_i for a wr command with ack_i=1, nack_o SHALL set.
REQ-030 ena_i low SHALL not abort an in-flight command; pushes remain accepted.
REQ-031 al_i high in any state: strobes 0 next cycle, command FIFO flushed, in-flight discarded, state IDLE, al_o set; al_i SHALL override a same-cycle cmd_ack_i (no result push) and a same-cycle push (dropped).
REQ-032 clr_i clears al_o and nack_o next cycle; a same-cycle al_i or NACK event SHALL win and set the flag.
REQ-033 Simultaneous push and pop on either FIFO SHALL leave its count unchanged; no push when full, no pop when empty; pointers wrap modulo DEPTH.
REQ-034 busy_o SHALL equal (state == ISSUE); cmd_cnt_o excludes the in-flight entry.

Reset
REQ-035 rst_i high at a clk_i edge SHALL empty both FIFOs, set state IDLE, and clear all strobes, dat_o, busy_o, al_o, nack_o, rx_valid_o and cmd_cnt_o, including mid-command.
REQ-036 After reset, cmd_ready_o SHALL be 1 and rx_dat_o SHALL be 0.

Verification
REQ-037 Push {sta,wr}, 0xA0 at cycle 10 (IDLE, ena_i=1) -> start_o=write_o=1, dat_o=0xA0 at cycle 11, held; cmd_ack_i at 20 -> strobes 0 at 21.
REQ-038 Push {rd,ack=1}; byte controller returns cmd_ack_i, ack_i=1, dat_i=0x5C -> rx_valid_o=1, rx_dat_o=0x15C.
REQ-039 Push DEPTH+1 entries with ena_i=0 -> cmd_ready_o=0 after DEPTH pushes, cmd_cnt_o=DEPTH; raise ena_i -> entries issued in push order with 2-cycle gaps.
REQ-040 al_i during ISSUE with 3 entries queued -> strobes 0 next cycle, cmd_cnt_o=0, al_o=1, cmd_ready_o=0; clr_i -> al_o=0, cmd_ready_o=1.
REQ-041 Result FIFO full and head rd=1 -> no issue; one rx pop -> issue next cycle.
REQ-042 rst_i asserted while busy_o=1 -> all outputs per REQ-035/036 next cycle; a later cmd_ack_i pushes no result.
